exe_muldiv: RTL and testbench

Multi-cycle RV32M execute unit for the RV32I_X core, parallel to the single-cycle integer execute stage. Decode issues MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ops over a valid/ready handshake. The unit iterates one bit per cycle, returns `rd` and its result to the exe→mem path over a second valid/ready handshake, and can be flushed by a taken branch or jump.

---
 rtl/exe_muldiv.sv | 170 +++++++++++++++++
 tb/tb_exe_muldiv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit with valid/ready in and out.
// Define EXE_MULDIV_FAST_MUL_EN for a single-cycle multiplier in the MUL state.
module exe_muldiv #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstl,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [31:0]     in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_pc,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t              state;
  logic [2:0]          op;
  logic [4:0]          rd_q;
  logic [31:0]         pc_q;
  logic [XLEN-1:0]     a;
  logic [XLEN-1:0]     b;
  logic [2*XLEN-1:0]   acc;
  logic [CNTW-1:0]     cnt;
  logic                neg_res;
  logic                spec;

  logic                s1_sgn, s2_sgn, s1_neg, s2_neg;
  logic [XLEN-1:0]     mag1, mag2, spec_res;
  logic                div0, ovf;
  logic [XLEN:0]       shl, sub_s;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, res;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign s1_sgn = (in_op == 3'b001) | (in_op == 3'b010) |
                  (in_op == 3'b100) | (in_op == 3'b110);
  assign s2_sgn = (in_op == 3'b001) | (in_op == 3'b100) |
                  (in_op == 3'b110);
  assign s1_neg = s1_sgn & in_rs1[XLEN-1];
  assign s2_neg = s2_sgn & in_rs2[XLEN-1];
  assign mag1   = s1_neg ? -in_rs1 : in_rs1;
  assign mag2   = s2_neg ? -in_rs2 : in_rs2;

  assign div0 = in_op[2] & (in_rs2 == '0);
  assign ovf  = in_op[2] & ~in_op[0] & (&in_rs2) &
                (in_rs1 == {1'b1, {(XLEN-1){1'b0}}});
  assign spec_res = div0 ? (in_op[1] ? in_rs1 : '1)
                         : (in_op[1] ? '0 : in_rs1);

  // restoring step: remainder lives in acc high half, quotient in low half
  assign shl   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign sub_s = shl - {1'b0, b};

`ifdef EXE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] mprod;
  assign mprod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`else
  logic [XLEN:0] add_s;
  assign add_s = {1'b0, acc[2*XLEN-1:XLEN]} +
                 (b[0] ? {1'b0, a} : {(XLEN+1){1'b0}});
`endif

  assign prod = neg_res ? -acc : acc;
  assign quo  = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  // sign fix and result select applied in FIX
  always_comb begin
    res = '0;
    if (spec)
      res = acc[XLEN-1:0];
    else if (!op[2])
      res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (!op[1])
      res = neg_res ? -quo : quo;
    else
      res = neg_res ? -rem : rem;
  end

  // control FSM, datapath iteration and registered outputs
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state     <= IDLE;
      op        <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_res   <= 1'b0;
      spec      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op      <= in_op;
          rd_q    <= in_rd;
          pc_q    <= in_pc;
          a       <= mag1;
          b       <= mag2;
          cnt     <= CNTW'(XLEN);
          neg_res <= (in_op[2] & in_op[1]) ? s1_neg : (s1_neg ^ s2_neg);
          spec    <= div0 | ovf;
          if (div0 | ovf) begin
            acc   <= {{XLEN{1'b0}}, spec_res};
            state <= FIX;
          end else if (in_op[2]) begin
            acc   <= {{XLEN{1'b0}}, mag1};
            state <= DIV;
          end else begin
            acc   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
`ifdef EXE_MULDIV_FAST_MUL_EN
          acc   <= mprod;
          state <= FIX;
`else
          acc <= {add_s, acc[XLEN-1:1]};
          b   <= b >> 1;
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) state <= FIX;
`endif
        end
        DIV: begin
          if (!sub_s[XLEN])
            acc <= {sub_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          else
            acc <= {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) state <= FIX;
        end
        FIX: begin
          out_valid <= 1'b1;
          out_data  <= res;
          out_rd    <= rd_q;
          out_pc    <= pc_q;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: vector table, random ops against a reference model,
// backpressure, flush and asynchronous reset sequences.
module tb_exe_muldiv;

`ifdef EXE_MULDIV_FAST_MUL_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  logic        clk = 1'b0;
  logic        rstl = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        busy;

  exe_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rstl(rstl),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_pc(out_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx, sy, uy;
    logic [63:0] p;
    logic        ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'b0, y});
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    ref_model = '0;
    case (op)
      3'd0: begin p = 64'(sx * sy); ref_model = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); ref_model = p[63:32]; end
      3'd2: begin p = 64'(sx * uy); ref_model = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; ref_model = p[63:32]; end
      3'd4: ref_model = (y == 0) ? 32'hFFFF_FFFF : ov ? x : 32'(sx / sy);
      3'd5: ref_model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: ref_model = (y == 0) ? x : ov ? 32'h0 : 32'(sx % sy);
      default: ref_model = (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input int lat, input logic [4:0] rd,
                        input logic [31:0] pc, input int stall,
                        input string nm);
    int   cyc;
    exp_t e;
    logic [31:0] held;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; in_pc = pc;
    e.data = res; e.rd = rd; e.pc = pc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_rd = 5'd31; in_pc = 32'hDEAD_BEEF; in_rs1 = '1;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) begin
      chk({nm, " timeout"}, 32'(cyc), 32'(lat));
      void'(sb.pop_front());
      return;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(lat));
    if (sb.size() == 0) begin
      chk({nm, " sb empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, " data"}, out_data, e.data);
      chk({nm, " rd"}, 32'(out_rd), 32'(e.rd));
      chk({nm, " pc"}, out_pc, e.pc);
    end
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({nm, " stall valid"}, 32'(out_valid), 32'd1);
      chk({nm, " stall data"}, out_data, held);
      chk({nm, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " post valid"}, 32'(out_valid), 32'd0);
    chk({nm, " post in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT};
    vt[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MLAT};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MLAT};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DLAT};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DLAT};
    vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        DLAT};
    vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         DLAT};
    vt[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vt[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};

    // reset state
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_rd", 32'(out_rd), 32'd0);
    chk("rst out_pc", out_pc, 32'd0);
    @(negedge clk);
    rstl = 1'b1;

    foreach (vt[i])
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat,
             5'(i), 32'h1000 + 32'(4 * i), 0, $sformatf("vec%0d", i));

    // random ops against the reference model
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          lat;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (!op[2]) lat = MLAT;
      else lat = DLAT;
      run_op(op, a, b, ref_model(op, a, b), lat, 5'(i + 3),
             32'h2000 + 32'(4 * i), 0, $sformatf("rnd%0d", i));
    end

    // backpressure: result held five cycles
    run_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, MLAT, 5'd9,
           32'h3000, 5, "stall");

    // flush at iteration 10
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_rs1 = 32'd100; in_rs2 = 32'd7;
    in_rd = 5'd4; in_pc = 32'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush busy", 32'(busy), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("flush no valid", 32'(seen), 32'd0);
    end
    run_op(3'd7, 32'd100, 32'd7, 32'd2, DLAT, 5'd6, 32'h4004, 0,
           "after flush");

    // flush with in_valid in IDLE: not accepted
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_rs1 = 32'd5; in_rs2 = 32'd0;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle flush in_ready", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("idle flush no valid", 32'(seen), 32'd0);
    end

    // asynchronous reset while holding a result
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_rs1 = 32'd5; in_rs2 = 32'd0;
    in_rd = 5'd7; in_pc = 32'h5000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst valid", 32'(out_valid), 32'd1);
    #2;
    rstl = 1'b0;
    #1;
    chk("async rst valid", 32'(out_valid), 32'd0);
    chk("async rst data", out_data, 32'd0);
    chk("async rst rd", 32'(out_rd), 32'd0);
    chk("async rst pc", out_pc, 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstl = 1'b1;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DLAT, 5'd0,
           32'h6000, 0, "after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
